attention_host_seq: RTL and testbench
=====================================

// Module: attention_host_seq
// PURPOSE
//  Host-side initiator for the self-attention accelerator job handshake: launches one job on
//  dut_valid, tracks dut_ready through busy/complete, then reads the result SRAM back and
//  streams each word out on a valid/ready port. Sits between the host/bench and the accelerator.
//  Measures job latency and flags handshake timeouts.
// PARAMETERS
//  ADDR_W       16  result SRAM address width (matches SRAM_ADDR_RANGE)
//  DATA_W       32  result SRAM data width (matches SRAM_DATA_RANGE)
//  ACK_TIMEOUT  8   max cycles after launch for dut_ready to fall before error
//  CNT_W        24  width of job cycle counter / done timeout counter
// PORTS
//  clk                       in   1       clock
//  reset                     in   1       asynchronous, active-high reset
//  start_i                   in   1       pulse: begin job (ignored unless idle)
//  result_count_i            in   ADDR_W  number of result words to read back (sampled at start)
//  busy_o                    out  1       job or readback in progress
//  done_o                    out  1       one-cycle pulse when readback completes
//  error_o                   out  1       sticky: ack or done timeout; cleared by next accepted start_i
//  cycle_count_o             out  CNT_W   cycles from dut_valid to dut_ready re-rise (held until next start)
//  dut_valid                 out  1       job request to accelerator
//  dut_ready                 in   1       accelerator idle/complete
//  host_result_read_address  out  ADDR_W  result SRAM read address
//  host_result_read_data     in   DATA_W  result SRAM read data, 1-cycle latency
//  rd_valid_o                out  1       stream word valid
//  rd_data_o                 out  DATA_W  stream word
//  rd_last_o                 out  1       marks word result_count_i-1
//  rd_ready_i                in   1       stream consumer ready
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, FIFO empty, address 0, counters 0.
//  One clock; interface is the other end of dut_valid/dut_ready. Reset mid-job aborts immediately;
//  the accelerator is not signalled.
//  FSM:
//   IDLE      : start_i && dut_ready -> LAUNCH; latch count, clear error_o/cycle counter.
//               start_i while !dut_ready is dropped (no error).
//   LAUNCH    : dut_valid=1 for exactly this cycle -> WAIT_ACK.
//   WAIT_ACK  : dut_ready==0 -> WAIT_DONE; ACK_TIMEOUT cycles with dut_ready still 1
//               -> error_o=1, ERROR.
//   WAIT_DONE : dut_ready==1 -> DRAIN (count==0 -> DONE); cycle counter saturating at all-ones
//               -> error_o=1, ERROR.
//   DRAIN     : issue reads addr 0..count-1. Data returns next cycle into a 2-entry FIFO.
//               Issue only when fifo_occ + inflight < 2 (never overflow, no stall loss).
//               Last word popped -> DONE.
//   DONE      : done_o=1 one cycle -> IDLE.
//   ERROR     : one cycle -> IDLE (error_o stays high).
//  Word path: rd_valid_o = FIFO not empty; pop on rd_valid_o && rd_ready_i; rd_data_o/rd_valid_o
//   held stable while stalled.
//  Throughput: one word per cycle with rd_ready_i held high; first word rd_valid_o 2 cycles
//   after DRAIN entry.
//  cycle_count_o: counts from the LAUNCH cycle (=1) through the cycle dut_ready is seen high
//   in WAIT_DONE; saturates.
//  busy_o = state != IDLE. Address outside DRAIN holds last value. count==0 skips DRAIN.
//  Simultaneous push and pop with FIFO full is legal; occupancy unchanged.
// STRUCTURE
//  Shared package attn_pkg: host state enum (3-bit), SRAM ADDR_W/DATA_W constants.
//  Sub-module: attn_skid_fifo (2-entry, DATA_W+1 wide, carries the last flag). The FSM and
//   counters stay in the top module.
// TESTING
//  1 start_i, count=4, dut_ready falls 1 cycle after dut_valid, rises 20 cycles later,
//    rd_ready_i=1 -> dut_valid 1 cycle; 4 words addr 0..3 back-to-back;
//    rd_last_o on word 3; done_o; cycle_count_o=22.
//  2 Same job, rd_ready_i toggles 1/0 every cycle -> no word lost or duplicated;
//    rd_data_o stable while stalled; FIFO never >2.
//  3 dut_ready never falls -> error_o=1 after 8 cycles; back to IDLE; no reads;
//    next start clears error_o.
//  4 count=0 -> dut handshake completes, no rd_valid_o, done_o pulses.
//  5 reset asserted in DRAIN after 2 words -> all outputs 0 same cycle; new start runs cleanly.
//  6 start_i while busy or while dut_ready=0 -> ignored; exactly one dut_valid per accepted job.

Source files
------------

// File: rtl/attn_pkg.sv
// attn_pkg: shared types for the attention host sequencer.
// Holds the state encoding, SRAM widths and the readback word.
package attn_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_DRAIN,
    S_DONE,
    S_ERROR
  } host_state_t;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } rd_word_t;
endpackage

// File: rtl/attention_host_seq_if.sv
// attention_host_seq_if: host, accelerator and stream signals.
// master = the sequencer, slave = host/accelerator/SRAM side.
interface attention_host_seq_if #(
  parameter int CNT_W = 24
) ();
  logic                      start_i;
  logic [attn_pkg::ADDR_W-1:0] result_count_i;
  logic                      busy_o;
  logic                      done_o;
  logic                      error_o;
  logic [CNT_W-1:0]          cycle_count_o;
  logic                      dut_valid;
  logic                      dut_ready;
  logic [attn_pkg::ADDR_W-1:0] host_result_read_address;
  logic [attn_pkg::DATA_W-1:0] host_result_read_data;
  logic                      rd_valid_o;
  logic [attn_pkg::DATA_W-1:0] rd_data_o;
  logic                      rd_last_o;
  logic                      rd_ready_i;

  modport master (
    input  start_i, result_count_i, dut_ready,
    input  host_result_read_data, rd_ready_i,
    output busy_o, done_o, error_o, cycle_count_o,
    output dut_valid, host_result_read_address,
    output rd_valid_o, rd_data_o, rd_last_o
  );

  modport slave (
    output start_i, result_count_i, dut_ready,
    output host_result_read_data, rd_ready_i,
    input  busy_o, done_o, error_o, cycle_count_o,
    input  dut_valid, host_result_read_address,
    input  rd_valid_o, rd_data_o, rd_last_o
  );
endinterface

// File: rtl/attn_skid_fifo.sv
// attn_skid_fifo: 2-entry FIFO for readback words plus last flag.
// Push while full is only legal together with a pop.
module attn_skid_fifo
  import attn_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     push,
  input  rd_word_t din,
  input  logic     pop,
  output rd_word_t dout,
  output logic     valid,
  output logic [1:0] occ
);
  rd_word_t mem [2];
  logic     wp;
  logic     rp;

  // storage, pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp     <= 1'b0;
      rp     <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp      <= ~wp;
      end
      if (pop) rp <= ~rp;
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

  assign dout  = mem[rp];
  assign valid = (occ != 2'd0);
endmodule

// File: rtl/attention_host_seq.sv
// attention_host_seq: launches one accelerator job, waits for it,
// then streams the result SRAM out through a 2-entry FIFO.
module attention_host_seq
  import attn_pkg::*;
#(
  parameter int ACK_TIMEOUT = 8,
  parameter int CNT_W       = 24
) (
  input logic clk,
  input logic reset,
  attention_host_seq_if.master bus
);
  localparam int AW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [AW-1:0] ACK_LAST = AW'(ACK_TIMEOUT - 1);

  host_state_t       state;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] iss_n;
  logic [ADDR_W-1:0] addr_q;
  logic [AW-1:0]     ack_n;
  logic [CNT_W-1:0]  cyc;
  logic [CNT_W-1:0]  cyc_inc;
  logic              cyc_max;
  logic              inflight;
  logic              inflight_last;
  logic              dut_valid_q;
  logic              done_q;
  logic              error_q;
  logic              issue;
  logic              pop;
  logic              fifo_valid;
  logic [1:0]        occ;
  logic [1:0]        room;
  rd_word_t          head;
  rd_word_t          push_w;

  assign cyc_max = &cyc;
  assign cyc_inc = cyc_max ? cyc : cyc + CNT_W'(1);
  assign pop     = fifo_valid && bus.rd_ready_i;
  // words that will sit in the FIFO after this edge, before new reads
  assign room    = occ - {1'b0, pop} + {1'b0, inflight};
  assign issue   = (state == S_DRAIN) && (iss_n != cnt_q)
                && (room < 2'd2);

  assign push_w.last = inflight_last;
  assign push_w.data = bus.host_result_read_data;

  attn_skid_fifo u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (inflight),
    .din   (push_w),
    .pop   (pop),
    .dout  (head),
    .valid (fifo_valid),
    .occ   (occ)
  );

  // job FSM, read issue and cycle/ack counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      cnt_q         <= '0;
      iss_n         <= '0;
      addr_q        <= '0;
      ack_n         <= '0;
      cyc           <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      dut_valid_q   <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      dut_valid_q   <= 1'b0;
      done_q        <= 1'b0;
      inflight      <= issue;
      inflight_last <= issue && (iss_n == cnt_q - ADDR_W'(1));
      if (issue) begin
        iss_n  <= iss_n + ADDR_W'(1);
        addr_q <= iss_n;
      end
      unique case (state)
        S_IDLE: begin
          if (bus.start_i && bus.dut_ready) begin
            state       <= S_LAUNCH;
            cnt_q       <= bus.result_count_i;
            iss_n       <= '0;
            ack_n       <= '0;
            cyc         <= '0;
            error_q     <= 1'b0;
            dut_valid_q <= 1'b1;
          end
        end
        S_LAUNCH: begin
          cyc   <= cyc_inc;
          state <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          cyc <= cyc_inc;
          if (!bus.dut_ready) begin
            state <= S_WAIT_DONE;
          end else if (ack_n == ACK_LAST) begin
            error_q <= 1'b1;
            state   <= S_ERROR;
          end else begin
            ack_n <= ack_n + AW'(1);
          end
        end
        S_WAIT_DONE: begin
          if (bus.dut_ready) begin
            cyc <= cyc_inc;
            if (cnt_q == '0) begin
              done_q <= 1'b1;
              state  <= S_DONE;
            end else begin
              state <= S_DRAIN;
            end
          end else if (cyc_max) begin
            error_q <= 1'b1;
            state   <= S_ERROR;
          end else begin
            cyc <= cyc_inc;
          end
        end
        S_DRAIN: begin
          if (pop && head.last) begin
            done_q <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        S_ERROR: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy_o        = (state != S_IDLE);
  assign bus.done_o        = done_q;
  assign bus.error_o       = error_q;
  assign bus.cycle_count_o = cyc;
  assign bus.dut_valid     = dut_valid_q;
  assign bus.host_result_read_address = issue ? iss_n : addr_q;
  assign bus.rd_valid_o    = fifo_valid;
  assign bus.rd_data_o     = head.data;
  assign bus.rd_last_o     = fifo_valid && head.last;
endmodule

// File: tb/tb_attention_host_seq.sv
// tb_attention_host_seq: job table plus reset/ignored-start
// sequences against an accelerator and SRAM model.
module tb_attention_host_seq;
  import attn_pkg::*;

  typedef struct {
    int count;
    bit ack;
    int lat;
    bit tog;
    bit dbl;
    int exp_words;
    bit exp_err;
    int exp_cyc;
    int exp_first;
    int exp_done;
    int exp_et;
  } vec_t;

  logic clk;
  logic reset;
  attention_host_seq_if bus ();

  attention_host_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int  n_pass;
  int  n_total;
  bit  acc_ack;
  int  acc_lat;
  bit  hold_low;
  bit  tog;

  int  cyc_n;
  int  dv_cnt;
  int  done_cnt;
  int  nwords;
  int  stall_bad;
  int  occ_bad;
  int  t_valid;
  int  t_done;
  int  t_vrise;
  int  t_err;
  logic [31:0] words [1024];
  bit          lasts [1024];
  bit          prev_v;
  bit          prev_r;
  bit          prev_l;
  bit          prev_e;
  logic [31:0] prev_d;

  vec_t vt [7];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // accelerator: drops ready after dut_valid, raises it acc_lat later
  initial begin
    bus.dut_ready = 1'b1;
    forever begin
      @(posedge clk);
      if (bus.dut_valid && acc_ack) begin
        #1 bus.dut_ready = 1'b0;
        repeat (acc_lat) @(posedge clk);
        #1 bus.dut_ready = 1'b1;
      end else begin
        #1 bus.dut_ready = !hold_low;
      end
    end
  end

  // result SRAM with one-cycle read latency
  initial begin
    logic [15:0] a;
    bus.host_result_read_data = '0;
    forever begin
      @(posedge clk);
      a = bus.host_result_read_address;
      #1 bus.host_result_read_data = 32'hBEEF0000 | 32'(a);
    end
  end

  // stream consumer: always ready or toggling
  initial begin
    bus.rd_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (tog) bus.rd_ready_i = ~bus.rd_ready_i;
      else     bus.rd_ready_i = 1'b1;
    end
  end

  // monitor: events, popped words, stall stability
  always @(negedge clk) begin
    cyc_n = cyc_n + 1;
    if (bus.dut_valid) begin
      dv_cnt  = dv_cnt + 1;
      t_valid = cyc_n;
    end
    if (bus.done_o) begin
      done_cnt = done_cnt + 1;
      t_done   = cyc_n;
    end
    if (bus.rd_valid_o && !prev_v) t_vrise = cyc_n;
    if (bus.error_o && !prev_e) t_err = cyc_n;
    if (prev_v && !prev_r &&
        (!bus.rd_valid_o || bus.rd_data_o != prev_d ||
         bus.rd_last_o != prev_l))
      stall_bad = stall_bad + 1;
    if (dut.u_fifo.occ > 2'd2) occ_bad = occ_bad + 1;
    if (bus.rd_valid_o && bus.rd_ready_i) begin
      words[nwords % 1024] = bus.rd_data_o;
      lasts[nwords % 1024] = bus.rd_last_o;
      nwords = nwords + 1;
    end
    prev_v = bus.rd_valid_o;
    prev_r = bus.rd_ready_i;
    prev_d = bus.rd_data_o;
    prev_l = bus.rd_last_o;
    prev_e = bus.error_o;
  end

  task automatic check(input string nm, input longint got,
                       input longint exp);
    n_total = n_total + 1;
    if (got == exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0d want %0d", nm, got, exp);
  endtask

  task automatic run_job(input vec_t v, input string id);
    int  b_dv, b_done, b_w, b_stall, b_occ;
    int  bad;
    int  nw;
    bit  to;
    acc_ack = v.ack;
    acc_lat = v.lat;
    tog     = v.tog;
    @(posedge clk);
    #1;
    b_dv    = dv_cnt;
    b_done  = done_cnt;
    b_w     = nwords;
    b_stall = stall_bad;
    b_occ   = occ_bad;
    bus.result_count_i = 16'(v.count);
    bus.start_i = 1'b1;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (v.dbl && i == 5) bus.start_i = 1'b1;
      if (i == 6) bus.start_i = 1'b0;
      if (!bus.busy_o) begin
        to = 1'b0;
        break;
      end
    end
    bus.start_i = 1'b0;
    repeat (3) @(negedge clk);
    check({id, " timeout"}, to, 0);
    nw = nwords - b_w;
    check({id, " words"}, nw, v.exp_words);
    check({id, " dut_valid pulses"}, dv_cnt - b_dv, 1);
    check({id, " done pulses"}, done_cnt - b_done,
          v.exp_err ? 0 : 1);
    check({id, " error_o"}, bus.error_o, v.exp_err);
    check({id, " busy_o idle"}, bus.busy_o, 0);
    check({id, " stall stability"}, stall_bad - b_stall, 0);
    check({id, " fifo occupancy"}, occ_bad - b_occ, 0);
    bad = 0;
    for (int k = 0; k < nw && k < 1024; k++) begin
      if (words[(b_w + k) % 1024] != (32'hBEEF0000 | 32'(k)))
        bad++;
      if (lasts[(b_w + k) % 1024] != (k == v.count - 1))
        bad++;
    end
    check({id, " data/last errors"}, bad, 0);
    if (v.exp_cyc >= 0)
      check({id, " cycle_count_o"}, bus.cycle_count_o, v.exp_cyc);
    if (v.exp_first >= 0)
      check({id, " first word latency"}, t_vrise - t_valid,
            v.exp_first);
    if (v.exp_done >= 0)
      check({id, " done latency"}, t_done - t_valid, v.exp_done);
    if (v.exp_et >= 0)
      check({id, " error latency"}, t_err - t_valid, v.exp_et);
  endtask

  initial begin
    vec_t pr;
    bit   to;
    int   b_dv;
    n_pass = 0; n_total = 0;
    cyc_n = 0; dv_cnt = 0; done_cnt = 0; nwords = 0;
    stall_bad = 0; occ_bad = 0;
    t_valid = 0; t_done = 0; t_vrise = 0; t_err = 0;
    prev_v = 0; prev_r = 0; prev_l = 0; prev_e = 0; prev_d = '0;
    acc_ack = 1'b1; acc_lat = 20; hold_low = 1'b0; tog = 1'b0;
    reset = 1'b1;
    bus.start_i = 1'b0;
    bus.result_count_i = '0;

    //       cnt ack lat tog dbl  wds err cyc fst dn  et
    vt[0] = '{4, 1, 20, 0, 0,   4, 0, 22, 24, 28, -1};
    vt[1] = '{4, 1, 20, 1, 0,   4, 0, 22, -1, -1, -1};
    vt[2] = '{4, 0,  0, 0, 0,   0, 1, -1, -1, -1,  9};
    vt[3] = '{0, 1,  5, 0, 0,   0, 0,  7, -1,  7, -1};
    vt[4] = '{1, 1,  3, 0, 0,   1, 0,  5,  7,  8, -1};
    vt[5] = '{7, 1,  2, 1, 0,   7, 0,  4, -1, -1, -1};
    vt[6] = '{3, 1,  4, 0, 1,   3, 0,  6, -1, -1, -1};

    repeat (2) @(posedge clk);
    #1;
    check("reset busy_o", bus.busy_o, 0);
    check("reset done_o", bus.done_o, 0);
    check("reset error_o", bus.error_o, 0);
    check("reset cycle_count_o", bus.cycle_count_o, 0);
    check("reset dut_valid", bus.dut_valid, 0);
    check("reset address", bus.host_result_read_address, 0);
    check("reset rd_valid_o", bus.rd_valid_o, 0);
    check("reset rd_last_o", bus.rd_last_o, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 7; i++)
      run_job(vt[i], $sformatf("v%0d", i));

    // start while accelerator not ready is dropped
    hold_low = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    b_dv = dv_cnt;
    bus.result_count_i = 16'd2;
    bus.start_i = 1'b1;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    repeat (3) @(negedge clk);
    check("ignored start busy_o", bus.busy_o, 0);
    check("ignored start dut_valid", dv_cnt - b_dv, 0);
    hold_low = 1'b0;
    repeat (2) @(posedge clk);

    // reset in the middle of readback
    acc_ack = 1'b1;
    acc_lat = 3;
    tog = 1'b0;
    @(posedge clk);
    #1;
    b_dv = nwords;
    bus.result_count_i = 16'd4;
    bus.start_i = 1'b1;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (nwords - b_dv >= 2) begin
        to = 1'b0;
        break;
      end
    end
    check("midreset reached drain", to, 0);
    check("midreset busy before", bus.busy_o, 1);
    reset = 1'b1;
    #1;
    check("midreset busy_o", bus.busy_o, 0);
    check("midreset rd_valid_o", bus.rd_valid_o, 0);
    check("midreset rd_data_o", bus.rd_data_o, 0);
    check("midreset rd_last_o", bus.rd_last_o, 0);
    check("midreset address", bus.host_result_read_address, 0);
    check("midreset cycle_count_o", bus.cycle_count_o, 0);
    check("midreset done_o", bus.done_o, 0);
    @(negedge clk);
    reset = 1'b0;
    pr = '{2, 1, 3, 0, 0, 2, 0, 5, 7, 9, -1};
    run_job(pr, "post-reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
